// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit with a fixed-latency busy window and HI/LO registers
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);
    logic [3:0]         cnt;
    logic [31:0]        temp_hi, temp_lo;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        abs_a, abs_b, uq, ur, sq, sr, res_hi, res_lo;
    logic               launch;

    // Result datapath; signed division works on magnitudes so 0x80000000/-1 falls out naturally,
    // and a zero divisor reloads the current HI/LO so the writeback leaves them unchanged.
    always_comb begin
        prod_s = $signed(A) * $signed(B);
        prod_u = {32'b0, A} * {32'b0, B};
        abs_a  = A[31] ? -A : A;
        abs_b  = B[31] ? -B : B;
        uq     = (B == 32'b0) ? 32'b0 : ((md_op == 3'd3) ? abs_a / abs_b : A / B);
        ur     = (B == 32'b0) ? 32'b0 : ((md_op == 3'd3) ? abs_a % abs_b : A % B);
        sq     = (A[31] ^ B[31]) ? -uq : uq;
        sr     = A[31] ? -ur : ur;
        {res_hi, res_lo} = (md_op == 3'd1) ? prod_s :
                           (md_op == 3'd2) ? prod_u :
                           (B == 32'b0)    ? {HI, LO} :
                           (md_op == 3'd3) ? {sr, sq} : {ur, uq};
        launch = start && !busy && (md_op >= 3'd1) && (md_op <= 3'd4);
    end

    // Launch, countdown and HI/LO writeback; busy blocks every new request.
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            cnt     <= 4'd0;
            temp_hi <= 32'b0;
            temp_lo <= 32'b0;
            HI      <= 32'b0;
            LO      <= 32'b0;
        end else if (busy) begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) begin
                HI   <= temp_hi;
                LO   <= temp_lo;
                busy <= 1'b0;
            end
        end else if (launch) begin
            busy    <= 1'b1;
            cnt     <= (md_op <= 3'd2) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
            temp_hi <= res_hi;
            temp_lo <= res_lo;
        end else if (start && md_op == 3'd5) begin
            HI <= A;
        end else if (start && md_op == 3'd6) begin
            LO <= A;
        end
    end
endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed self-checking bench for e_mdu
module tb_e_mdu;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  md_op = 3'd0;
    logic [31:0] A = 32'b0;
    logic [31:0] B = 32'b0;
    logic        busy;
    logic [31:0] HI, LO;
    int          tests = 0;
    int          fails = 0;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .A(A), .B(B), .busy(busy), .HI(HI), .LO(LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        md_op = op;
        A = a;
        B = b;
        tick();
        start = 1'b0;
        md_op = 3'd0;
    endtask

    task automatic busy_run(input int n, input logic [31:0] hi, input logic [31:0] lo);
        for (int i = 0; i < n; i++) begin
            chk("busy_high", {31'b0, busy}, 32'd1);
            chk("hi_hold", HI, hi);
            chk("lo_hold", LO, lo);
            tick();
        end
    endtask

    initial begin
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_hi", HI, 32'h0);
        chk("reset_lo", LO, 32'h0);

        issue(3'd1, 32'hFFFFFFFF, 32'h00000002);
        busy_run(5, 32'h0, 32'h0);
        chk("mult_busy_done", {31'b0, busy}, 32'd0);
        chk("mult_hi", HI, 32'hFFFFFFFF);
        chk("mult_lo", LO, 32'hFFFFFFFE);

        issue(3'd2, 32'hFFFFFFFF, 32'h00000002);
        busy_run(5, 32'hFFFFFFFF, 32'hFFFFFFFE);
        chk("multu_busy_done", {31'b0, busy}, 32'd0);
        chk("multu_hi", HI, 32'h00000001);
        chk("multu_lo", LO, 32'hFFFFFFFE);

        issue(3'd3, 32'hFFFFFFF9, 32'h00000002);
        busy_run(10, 32'h00000001, 32'hFFFFFFFE);
        chk("div_busy_done", {31'b0, busy}, 32'd0);
        chk("div_hi", HI, 32'hFFFFFFFF);
        chk("div_lo", LO, 32'hFFFFFFFD);

        issue(3'd4, 32'h00000007, 32'h00000002);
        busy_run(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        chk("divu_hi", HI, 32'h00000001);
        chk("divu_lo", LO, 32'h00000003);

        issue(3'd5, 32'h00000011, 32'h0);
        chk("mthi_busy", {31'b0, busy}, 32'd0);
        chk("mthi_hi", HI, 32'h00000011);
        issue(3'd6, 32'h00000022, 32'h0);
        chk("mtlo_busy", {31'b0, busy}, 32'd0);
        chk("mtlo_lo", LO, 32'h00000022);
        chk("mtlo_hi_kept", HI, 32'h00000011);

        issue(3'd3, 32'h00000005, 32'h00000000);
        chk("div0_c1", {31'b0, busy}, 32'd1);
        issue(3'd5, 32'h00000055, 32'h0);
        chk("div0_c2", {31'b0, busy}, 32'd1);
        chk("mthi_in_busy", HI, 32'h00000011);
        issue(3'd1, 32'h00000003, 32'h00000004);
        busy_run(8, 32'h00000011, 32'h00000022);
        chk("div0_busy_done", {31'b0, busy}, 32'd0);
        chk("div0_hi", HI, 32'h00000011);
        chk("div0_lo", LO, 32'h00000022);
        tick();
        chk("no_relaunch_busy", {31'b0, busy}, 32'd0);
        chk("no_relaunch_lo", LO, 32'h00000022);

        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        busy_run(10, 32'h00000011, 32'h00000022);
        chk("ovf_hi", HI, 32'h00000000);
        chk("ovf_lo", LO, 32'h80000000);

        issue(3'd7, 32'h12345678, 32'h1);
        chk("op7_busy", {31'b0, busy}, 32'd0);
        chk("op7_hi", HI, 32'h00000000);
        chk("op7_lo", LO, 32'h80000000);

        issue(3'd1, 32'h00000003, 32'h00000004);
        chk("rst_c1", {31'b0, busy}, 32'd1);
        tick();
        chk("rst_c2", {31'b0, busy}, 32'd1);
        tick();
        chk("rst_c3", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_busy", {31'b0, busy}, 32'd0);
        chk("rst_mid_hi", HI, 32'h0);
        chk("rst_mid_lo", LO, 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rst_no_write_lo", LO, 32'h0);
            chk("rst_no_write_busy", {31'b0, busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
